// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin over WIDTH cycles, LSB first, with start/done handshake.
// Optional signed-overflow flag output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow;
   logic [CW-1:0]    count;

   logic             x;
   logic             y;
   logic             d;
   logic             r_next;
   logic             last_bit;
   logic [WIDTH-1:0] res_final;

   // Full-subtractor cell operating on the current LSBs and the carried borrow.
   assign x         = a_sr[0];
   assign y         = b_sr[0];
   assign d         = x ^ y ^ borrow;
   assign r_next    = (~x & y) | (~(x ^ y) & borrow);
   assign last_bit  = (count == CW'(WIDTH - 1));
   assign res_final = {d, res_sr[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb;
   logic b_msb;

   // Captured operand MSBs are kept because the shift registers lose them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
         end
         if (state == SHIFT && last_bit) begin
            ovf <= (a_msb != b_msb) && (d != a_msb);
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         count  <= '0;
         diff   <= '0;
         bout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  borrow <= bin;
                  count  <= '0;
               end
            end
            SHIFT: begin
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               res_sr <= res_final;
               borrow <= r_next;
               count  <= count + 1'b1;
               // diff/bout change only at completion so consumers see a stable result.
               if (last_bit) begin
                  diff <= res_final;
                  bout <= r_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
